// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron.
// Integrates weighted pre-synaptic spikes into a membrane potential with a
// shift-based leak. It emits a single-cycle post-synaptic spike when the
// potential reaches the threshold, and then blanks its input for a fixed
// refractory period.
//
// state      | meaning
// -----------+------------------------------------------------------------
// INTEGRATE  | leak and accumulate each cycle, fire when sum >= THRESHOLD
// REFRACTORY | vmem held at V_RESET, inputs ignored, rcnt counts down to 1
module lif_neuron #(
    parameter int W_WIDTH        = 8,
    parameter int VMEM_W         = 12,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4,
    parameter int V_RESET        = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pre_spike,
    input  logic [W_WIDTH-1:0] weight,
    output logic               post_spike,
    output logic [VMEM_W-1:0]  vmem,
    output logic               refractory,
    output logic [7:0]         spike_count
);

    // The sum must hold the largest leaked potential plus the largest weight
    // without wrapping, whichever of the two operands is wider.
    localparam int SUM_W  = ((VMEM_W > W_WIDTH) ? VMEM_W : W_WIDTH) + 1;
    localparam int RCNT_W = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);

    localparam logic [SUM_W-1:0]  VMAX     = SUM_W'((1 << VMEM_W) - 1);
    localparam logic [VMEM_W-1:0] VTHRESH  = VMEM_W'(THRESHOLD);
    localparam logic [VMEM_W-1:0] VRST     = VMEM_W'(V_RESET);
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REFRACT_CYCLES);
    localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);

    typedef enum logic [0:0] {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [RCNT_W-1:0]  rcnt, rcnt_nxt;
    logic [VMEM_W-1:0]  vmem_nxt;
    logic               post_nxt;
    logic [7:0]         count_nxt;

    logic [VMEM_W-1:0]  leaked;
    logic [SUM_W-1:0]   sum_raw;
    logic [VMEM_W-1:0]  sum_sat;

    // Leak-then-add datapath. The sum saturates instead of wrapping.
    always_comb begin
        leaked  = vmem - (vmem >> LEAK_SHIFT);
        sum_raw = SUM_W'(leaked) + (pre_spike ? SUM_W'(weight) : '0);
        sum_sat = (sum_raw > VMAX) ? VMAX[VMEM_W-1:0] : sum_raw[VMEM_W-1:0];
    end

    // State register and all output registers. Reset takes priority over firing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INTEGRATE;
            rcnt        <= '0;
            vmem        <= VRST;
            post_spike  <= 1'b0;
            spike_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            rcnt        <= rcnt_nxt;
            vmem        <= vmem_nxt;
            post_spike  <= post_nxt;
            spike_count <= count_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        vmem_nxt  = vmem;
        post_nxt  = 1'b0;
        count_nxt = spike_count;
        unique case (state)
            INTEGRATE: begin
                if (sum_sat >= VTHRESH) begin
                    post_nxt  = 1'b1;
                    vmem_nxt  = VRST;
                    state_nxt = REFRACTORY;
                    rcnt_nxt  = RCNT_MAX;
                    if (spike_count != 8'hFF)
                        count_nxt = spike_count + 8'd1;
                end else begin
                    vmem_nxt = sum_sat;
                end
            end
            REFRACTORY: begin
                vmem_nxt = VRST;
                if (rcnt == RCNT_ONE) begin
                    state_nxt = INTEGRATE;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt - RCNT_ONE;
                end
            end
            default: begin
                state_nxt = INTEGRATE;
                rcnt_nxt  = '0;
                vmem_nxt  = VRST;
            end
        endcase
    end

    // State is itself a register, so refractory is a flop output.
    assign refractory = (state == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron with default parameters.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pre_spike;
    logic [7:0]  weight;
    logic        post_spike;
    logic [11:0] vmem;
    logic        refractory;
    logic [7:0]  spike_count;

    int checks = 0;
    int passes = 0;

    lif_neuron dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_spike),
        .weight      (weight),
        .post_spike  (post_spike),
        .vmem        (vmem),
        .refractory  (refractory),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pre_spike = 1'b0; weight = 8'd0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pre_spike = 1'b1; weight = 8'd255;
        step();
        checks++; if (vmem !== 12'd0) $display("FAIL reset_vmem got %0d want 0", vmem); else passes++;
        checks++; if (post_spike !== 1'b0) $display("FAIL reset_post got %b want 0", post_spike); else passes++;
        checks++; if (refractory !== 1'b0) $display("FAIL reset_refr got %b want 0", refractory); else passes++;
        checks++; if (spike_count !== 8'd0) $display("FAIL reset_count got %0d want 0", spike_count); else passes++;
        rst_n = 1'b1; pre_spike = 1'b0; weight = 8'd0;
    endtask

    task automatic test_accumulate();
        do_reset();
        pre_spike = 1'b1; weight = 8'd100;
        step();
        checks++; if (vmem !== 12'd100) $display("FAIL acc_vmem1 got %0d want 100", vmem); else passes++;
        step();
        checks++; if (vmem !== 12'd188) $display("FAIL acc_vmem2 got %0d want 188", vmem); else passes++;
        checks++; if (post_spike !== 1'b0) $display("FAIL acc_nofire got %b want 0", post_spike); else passes++;
        step();
        checks++; if (post_spike !== 1'b1) $display("FAIL acc_fire got %b want 1", post_spike); else passes++;
        checks++; if (vmem !== 12'd0) $display("FAIL acc_vmem3 got %0d want 0", vmem); else passes++;
        checks++; if (spike_count !== 8'd1) $display("FAIL acc_count got %0d want 1", spike_count); else passes++;
        checks++; if (refractory !== 1'b1) $display("FAIL acc_refr got %b want 1", refractory); else passes++;
        pre_spike = 1'b0;
    endtask

    task automatic test_leak();
        logic [11:0] exp_seq [8] = '{12'd100, 12'd88, 12'd77, 12'd68, 12'd60, 12'd53, 12'd47, 12'd42};
        do_reset();
        pre_spike = 1'b1; weight = 8'd100;
        for (int i = 0; i < 8; i++) begin
            step();
            pre_spike = 1'b0;
            checks++; if (vmem !== exp_seq[i]) $display("FAIL leak_vmem[%0d] got %0d want %0d", i, vmem, exp_seq[i]); else passes++;
            checks++; if (post_spike !== 1'b0) $display("FAIL leak_post[%0d] got %b want 0", i, post_spike); else passes++;
        end
    endtask

    task automatic test_leak_floor();
        do_reset();
        pre_spike = 1'b1; weight = 8'd7;
        step();
        pre_spike = 1'b0;
        checks++; if (vmem !== 12'd7) $display("FAIL floor_load got %0d want 7", vmem); else passes++;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (vmem !== 12'd7) $display("FAIL floor_vmem[%0d] got %0d want 7", i, vmem); else passes++;
            checks++; if (post_spike !== 1'b0) $display("FAIL floor_post[%0d] got %b want 0", i, post_spike); else passes++;
        end
    endtask

    task automatic test_refractory();
        do_reset();
        pre_spike = 1'b1; weight = 8'd255;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++; if (post_spike !== ((k % 5) == 0)) $display("FAIL refr_post[%0d] got %b want %b", k, post_spike, (k % 5) == 0); else passes++;
            checks++; if (refractory !== ((k % 5) < 4)) $display("FAIL refr_flag[%0d] got %b want %b", k, refractory, (k % 5) < 4); else passes++;
            checks++; if (vmem !== 12'd0) $display("FAIL refr_vmem[%0d] got %0d want 0", k, vmem); else passes++;
        end
        pre_spike = 1'b0;
    endtask

    // A spike arriving on the final refractory edge is dropped entirely.
    task automatic test_last_refract_ignore();
        do_reset();
        pre_spike = 1'b1; weight = 8'd255;
        step();
        pre_spike = 1'b0;
        step(); step(); step();
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        checks++; if (refractory !== 1'b0) $display("FAIL ign_refr got %b want 0", refractory); else passes++;
        checks++; if (post_spike !== 1'b0) $display("FAIL ign_post got %b want 0", post_spike); else passes++;
        checks++; if (vmem !== 12'd0) $display("FAIL ign_vmem got %0d want 0", vmem); else passes++;
        step();
        checks++; if (vmem !== 12'd0) $display("FAIL ign_vmem2 got %0d want 0", vmem); else passes++;
        checks++; if (spike_count !== 8'd1) $display("FAIL ign_count got %0d want 1", spike_count); else passes++;
    endtask

    task automatic test_saturation();
        int exp_cnt = 0;
        do_reset();
        pre_spike = 1'b1; weight = 8'd255;
        for (int k = 0; k < 1400; k++) begin
            step();
            if ((k % 5) == 0 && exp_cnt < 255) exp_cnt++;
            checks++; if (post_spike !== ((k % 5) == 0)) $display("FAIL sat_post[%0d] got %b want %b", k, post_spike, (k % 5) == 0); else passes++;
            checks++; if (spike_count !== 8'(exp_cnt)) $display("FAIL sat_count[%0d] got %0d want %0d", k, spike_count, exp_cnt); else passes++;
        end
        checks++; if (spike_count !== 8'd255) $display("FAIL sat_final got %0d want 255", spike_count); else passes++;
        pre_spike = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pre_spike = 1'b1; weight = 8'd255;
        step();
        pre_spike = 1'b0;
        step();
        checks++; if (refractory !== 1'b1) $display("FAIL mid_pre_refr got %b want 1", refractory); else passes++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (vmem !== 12'd0) $display("FAIL mid_vmem got %0d want 0", vmem); else passes++;
        checks++; if (refractory !== 1'b0) $display("FAIL mid_refr got %b want 0", refractory); else passes++;
        checks++; if (spike_count !== 8'd0) $display("FAIL mid_count got %0d want 0", spike_count); else passes++;
        checks++; if (post_spike !== 1'b0) $display("FAIL mid_post got %b want 0", post_spike); else passes++;
        pre_spike = 1'b1; weight = 8'd200;
        step();
        pre_spike = 1'b0;
        checks++; if (post_spike !== 1'b1) $display("FAIL mid_fire got %b want 1", post_spike); else passes++;
        checks++; if (spike_count !== 8'd1) $display("FAIL mid_fire_count got %0d want 1", spike_count); else passes++;
        checks++; if (vmem !== 12'd0) $display("FAIL mid_fire_vmem got %0d want 0", vmem); else passes++;
    endtask

    initial begin
        rst_n = 1'b0; pre_spike = 1'b0; weight = 8'd0;
        test_reset();
        test_accumulate();
        test_leak();
        test_leak_floor();
        test_refractory();
        test_last_refract_ignore();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
